// File: rtl/wbrgb_rx.sv
// wbrgb_rx: WS2812-coded serial line receiver with a 4-deep word FIFO
// and a Wishbone register slave (DATA, STATUS, CTRL).
module wbrgb_rx #(
   parameter int BIT_THR  = 31,
   parameter int MIN_HIGH = 5,
   parameter int MAX_HIGH = 62,
   parameter int RST_CYC  = 2500
) (
   input  logic        clkin,
   input  logic        resetn,
   input  logic        rgb_in,
   input  logic        slv_ext_stb_o,
   input  logic        slv_ext_we_o,
   input  logic        slv_ext_cyc_o,
   input  logic [3:0]  slv_ext_adr_o,
   input  logic [31:0] slv_ext_wdata_o,
   input  logic [3:0]  slv_ext_sel_o,
   output logic        slv_ext_ack_i,
   output logic [31:0] slv_ext_rdata_i,
   output logic        rx_irq
);

   localparam int LW = $clog2(RST_CYC + 1);
   localparam int HW = $clog2(MAX_HIGH + 1);

   typedef enum logic [1:0] {
      S_SYNC, S_ARMED, S_HIGH, S_LOW
   } st_t;

   st_t           st_q, st_d;
   logic          s1_q, s2_q;
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [23:0]   sh_q, sh_d;
   logic [4:0]    bcnt_q, bcnt_d;
   logic          bit_w, push_w;
   logic          set_et, set_ep, set_fd;
   logic [23:0]   word_w;

   logic [23:0]   mem_q [4];
   logic [1:0]    wp_q, rp_q;
   logic [2:0]    lvl_q;
   logic          ovf_q, et_q, ep_q, fd_q;
   logic          en_q, ie_q, ack_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          req, rd, wr, nonempty, full;
   logic          pop, flush, push_ok, ovf_ev;
   logic [3:0]    clr;
   logic          unused_in;

   assign unused_in = ^{slv_ext_sel_o,
                        slv_ext_wdata_o[31:8],
                        slv_ext_wdata_o[3]};

   // Two-flop synchronizer for the asynchronous line.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= rgb_in;
         s2_q <= s1_q;
      end
   end

   // Decoder state register.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         st_q   <= S_SYNC;
         lcnt_q <= '0;
         hcnt_q <= '0;
         sh_q   <= '0;
         bcnt_q <= '0;
      end else begin
         st_q   <= st_d;
         lcnt_q <= lcnt_d;
         hcnt_q <= hcnt_d;
         sh_q   <= sh_d;
         bcnt_q <= bcnt_d;
      end
   end

   // Decoder next state; ARMED/LOW always follow a low sample, so a
   // high sample there is a rising edge, and a low one in HIGH a fall.
   // The rise cycle is counted as the first high cycle of the pulse.
   always_comb begin
      st_d   = st_q;
      lcnt_d = lcnt_q;
      hcnt_d = hcnt_q;
      sh_d   = sh_q;
      bcnt_d = bcnt_q;
      push_w = 1'b0;
      set_et = 1'b0;
      set_ep = 1'b0;
      set_fd = 1'b0;
      bit_w  = (hcnt_q >= HW'(BIT_THR));
      word_w = {sh_q[22:0], bit_w};
      if (!en_q) begin
         st_d   = S_SYNC;
         lcnt_d = '0;
         bcnt_d = '0;
      end else begin
         unique case (st_q)
            S_SYNC: begin
               bcnt_d = '0;
               if (s2_q) begin
                  lcnt_d = '0;
               end else if (lcnt_q == LW'(RST_CYC - 1)) begin
                  lcnt_d = '0;
                  st_d   = S_ARMED;
               end else begin
                  lcnt_d = lcnt_q + LW'(1);
               end
            end
            S_ARMED: begin
               if (s2_q) begin
                  hcnt_d = HW'(1);
                  st_d   = S_HIGH;
               end
            end
            S_HIGH: begin
               if (s2_q) begin
                  if (hcnt_q == HW'(MAX_HIGH)) begin
                     set_et = 1'b1;
                     st_d   = S_SYNC;
                     lcnt_d = '0;
                     bcnt_d = '0;
                  end else begin
                     hcnt_d = hcnt_q + HW'(1);
                  end
               end else if (hcnt_q < HW'(MIN_HIGH)) begin
                  set_et = 1'b1;
                  st_d   = S_SYNC;
                  lcnt_d = '0;
                  bcnt_d = '0;
               end else begin
                  sh_d   = word_w;
                  lcnt_d = LW'(1);
                  st_d   = S_LOW;
                  if (bcnt_q == 5'd23) begin
                     push_w = 1'b1;
                     bcnt_d = '0;
                  end else begin
                     bcnt_d = bcnt_q + 5'd1;
                  end
               end
            end
            S_LOW: begin
               if (s2_q) begin
                  hcnt_d = HW'(1);
                  st_d   = S_HIGH;
               end else if (lcnt_q == LW'(RST_CYC - 1)) begin
                  set_fd = 1'b1;
                  set_ep = (bcnt_q != 5'd0);
                  bcnt_d = '0;
                  lcnt_d = '0;
                  st_d   = S_ARMED;
               end else begin
                  lcnt_d = lcnt_q + LW'(1);
               end
            end
         endcase
      end
   end

   assign req      = slv_ext_stb_o & slv_ext_cyc_o & ~ack_q;
   assign rd       = req & ~slv_ext_we_o;
   assign wr       = req & slv_ext_we_o;
   assign nonempty = (lvl_q != 3'd0);
   assign full     = (lvl_q == 3'd4);
   assign pop      = rd & (slv_ext_adr_o == 4'h2) & nonempty;
   assign flush    = wr & (slv_ext_adr_o == 4'h4) & slv_ext_wdata_o[2];
   assign push_ok  = push_w & (~full | pop);
   assign ovf_ev   = push_w & full & ~pop;
   assign clr      = (wr && slv_ext_adr_o == 4'h3) ?
                     slv_ext_wdata_o[7:4] : 4'h0;

   // Register read mux; writes return zero.
   always_comb begin
      rdata_d = '0;
      if (!slv_ext_we_o) begin
         case (slv_ext_adr_o)
            4'h2: rdata_d = nonempty ?
                            {1'b1, 7'b0, mem_q[rp_q]} : 32'h0;
            4'h3: rdata_d = {24'b0, fd_q, ep_q, et_q, ovf_q,
                             1'b0, lvl_q};
            4'h4: rdata_d = {30'b0, ie_q, en_q};
            default: rdata_d = '0;
         endcase
      end
   end

   // FIFO storage; pointers and level live in the reset block below.
   always_ff @(posedge clkin) begin
      if (push_ok && !flush) mem_q[wp_q] <= word_w;
   end

   // FIFO pointers, sticky flags, CTRL and bus response.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         wp_q    <= '0;
         rp_q    <= '0;
         lvl_q   <= '0;
         ovf_q   <= 1'b0;
         et_q    <= 1'b0;
         ep_q    <= 1'b0;
         fd_q    <= 1'b0;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
         end else begin
            if (push_ok) wp_q <= wp_q + 2'd1;
            if (pop) rp_q <= rp_q + 2'd1;
            lvl_q <= lvl_q + {2'b0, push_ok} - {2'b0, pop};
         end
         ovf_q <= ovf_ev | (ovf_q & ~clr[0]);
         et_q  <= set_et | (et_q & ~clr[1]);
         ep_q  <= set_ep | (ep_q & ~clr[2]);
         fd_q  <= set_fd | (fd_q & ~clr[3]);
         if (wr && slv_ext_adr_o == 4'h4) begin
            en_q <= slv_ext_wdata_o[0];
            ie_q <= slv_ext_wdata_o[1];
         end
         ack_q <= req;
         if (req) rdata_q <= rdata_d;
      end
   end

   assign slv_ext_ack_i   = ack_q;
   assign slv_ext_rdata_i = rdata_q;
   assign rx_irq          = ie_q & nonempty;

endmodule

// File: tb/tb_wbrgb_rx.sv
// tb_wbrgb_rx: register table, directed frame sequences and random
// frames checked against a queue model of the received words.
module tb_wbrgb_rx;

   localparam int BIT_THR  = 31;
   localparam int MIN_HIGH = 5;
   localparam int MAX_HIGH = 62;
   localparam int RST_CYC  = 2500;
   localparam int LOWEND   = RST_CYC + 10;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        rgb = 1'b0;
   logic        stb = 1'b0, we = 1'b0, cyc = 1'b0;
   logic [3:0]  adr = 4'h0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] wd = 32'h0;
   logic        ack;
   logic [31:0] rdata;
   logic        irq;

   int nchk = 0;
   int nfail = 0;
   logic [23:0] mq[$];
   bit movf;
   bit mon = 1'b0;
   bit irq_seen = 1'b0;
   logic [31:0] v;
   logic [23:0] w;

   typedef struct {
      logic        we;
      logic [3:0]  adr;
      logic [31:0] wd;
      logic [31:0] exp;
      string       nm;
   } vec_t;
   vec_t tbl[$];

   wbrgb_rx dut (
      .clkin(clk), .resetn(resetn), .rgb_in(rgb),
      .slv_ext_stb_o(stb), .slv_ext_we_o(we), .slv_ext_cyc_o(cyc),
      .slv_ext_adr_o(adr), .slv_ext_wdata_o(wd),
      .slv_ext_sel_o(sel), .slv_ext_ack_i(ack),
      .slv_ext_rdata_i(rdata), .rx_irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mon && irq) irq_seen = 1'b1;

   function automatic vec_t mk(logic w_, logic [3:0] a,
                               logic [31:0] d, logic [31:0] e,
                               string n);
      vec_t r;
      r.we = w_; r.adr = a; r.wd = d; r.exp = e; r.nm = n;
      return r;
   endfunction

   function automatic logic [31:0] stv(int lvl, bit ov, bit et,
                                       bit ep, bit fd);
      logic [2:0] l;
      l = 3'(lvl);
      return {24'b0, fd, ep, et, ov, 1'b0, l};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb(logic w_, logic [3:0] a, logic [31:0] d,
                     output logic [31:0] r);
      bit got;
      stb = 1'b1; cyc = 1'b1; we = w_; adr = a; wd = d;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack) got = 1'b1;
      end
      r = rdata;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      if (!got) begin
         nchk++;
         nfail++;
         $display("FAIL wb_ack adr %h: got no ack want ack", a);
      end
   endtask

   task automatic rdc(logic [3:0] a, logic [31:0] e, string nm);
      logic [31:0] r;
      wb(1'b0, a, 32'h0, r);
      chk(nm, r, e);
   endtask

   task automatic wr(logic [3:0] a, logic [31:0] d);
      logic [31:0] r;
      wb(1'b1, a, d, r);
   endtask

   task automatic low(int n);
      rgb = 1'b0;
      step(n);
   endtask

   task automatic pulse(int h, int l);
      rgb = 1'b1;
      step(h);
      rgb = 1'b0;
      step(l);
   endtask

   task automatic fword(logic [23:0] x);
      for (int i = 23; i >= 0; i--)
         pulse(x[i] ? 42 : 20, x[i] ? 20 : 42);
   endtask

   task automatic rbit(logic b);
      int h;
      h = b ? int'($urandom_range(MAX_HIGH, BIT_THR))
            : int'($urandom_range(BIT_THR - 1, MIN_HIGH));
      pulse(h, int'($urandom_range(12, 2)));
   endtask

   task automatic rword(logic [23:0] x);
      for (int i = 23; i >= 0; i--) rbit(x[i]);
   endtask

   task automatic mpush(logic [23:0] x);
      if (mq.size() < 4) mq.push_back(x);
      else movf = 1'b1;
   endtask

   initial begin
      int bw[4];
      int n;
      bw = '{MIN_HIGH, BIT_THR - 1, BIT_THR, MAX_HIGH};

      step(4);
      chk("rst_ack", {31'b0, ack}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      resetn = 1'b1;
      step(2);

      tbl.push_back(mk(0, 4'h3, 0, 32'h0, "st_rst"));
      tbl.push_back(mk(0, 4'h4, 0, 32'h0, "ctrl_rst"));
      tbl.push_back(mk(0, 4'h2, 0, 32'h0, "data_rst"));
      tbl.push_back(mk(0, 4'h7, 0, 32'h0, "adr7_rst"));
      tbl.push_back(mk(1, 4'h4, 32'h7, 0, ""));
      tbl.push_back(mk(0, 4'h4, 0, 32'h3, "ctrl_flush_rd"));
      tbl.push_back(mk(1, 4'h7, 32'hFFFFFFFF, 0, ""));
      tbl.push_back(mk(0, 4'h7, 0, 32'h0, "adr7_wr_ign"));
      tbl.push_back(mk(1, 4'h2, 32'hFFFFFFFF, 0, ""));
      tbl.push_back(mk(0, 4'h3, 0, 32'h0, "data_wr_ign"));
      tbl.push_back(mk(1, 4'h4, 32'h2, 0, ""));
      tbl.push_back(mk(0, 4'h4, 0, 32'h2, "ctrl_ie"));
      tbl.push_back(mk(1, 4'h4, 32'hFFFFFFFB, 0, ""));
      tbl.push_back(mk(0, 4'h4, 0, 32'h3, "ctrl_en_ie"));
      foreach (tbl[i]) begin
         wb(tbl[i].we, tbl[i].adr, tbl[i].wd, v);
         if (!tbl[i].we) chk(tbl[i].nm, v, tbl[i].exp);
      end

      low(LOWEND);
      fword(24'hA5C3F0);
      low(LOWEND);
      chk("irq_set", {31'b0, irq}, 32'h1);
      rdc(4'h3, stv(1, 0, 0, 0, 1), "first_st");
      rdc(4'h2, 32'h80A5C3F0, "first_data");
      rdc(4'h3, stv(0, 0, 0, 0, 1), "first_st_after");
      chk("irq_clr", {31'b0, irq}, 32'h0);
      wr(4'h3, 32'hF0);
      rdc(4'h3, 32'h0, "st_cleared");

      rword(24'h111111);
      rword(24'h222222);
      rword(24'h333333);
      rword(24'h444444);
      rword(24'h555555);
      low(LOWEND);
      rdc(4'h3, stv(4, 1, 0, 0, 1), "ovf_st");
      wr(4'h3, 32'h10);
      rdc(4'h3, stv(4, 0, 0, 0, 1), "ovf_clr_only");
      rdc(4'h2, 32'h80111111, "ovf_d0");
      rdc(4'h2, 32'h80222222, "ovf_d1");
      rdc(4'h2, 32'h80333333, "ovf_d2");
      rdc(4'h2, 32'h80444444, "ovf_d3");
      rdc(4'h2, 32'h0, "ovf_empty");
      wr(4'h3, 32'hF0);

      for (int f = 0; f < 3; f++) begin
         movf = 1'b0;
         n = int'($urandom_range(5, 1));
         for (int k = 0; k < n; k++) begin
            w = 24'($urandom);
            rword(w);
            mpush(w);
         end
         low(LOWEND);
         rdc(4'h3, stv(mq.size(), movf, 0, 0, 1), "rnd_st");
         while (mq.size() > 0) begin
            w = mq.pop_front();
            rdc(4'h2, {8'h80, w}, "rnd_data");
         end
         rdc(4'h2, 32'h0, "rnd_empty");
         wr(4'h3, 32'hF0);
      end

      wb(1'b0, 4'h2, 32'h0, v);
      chk("empty_rd", v, 32'h0);
      step(1);
      chk("ack_1cyc", {31'b0, ack}, 32'h0);
      rdc(4'h7, 32'h0, "adr7_rd");

      for (int i = 0; i < 8; i++) rbit(1'($urandom));
      pulse(3, 20);
      rword(24'h123456);
      low(LOWEND);
      rdc(4'h3, stv(0, 0, 1, 0, 0), "short_err");
      wr(4'h3, 32'h20);
      pulse(MAX_HIGH, 10);
      pulse(MAX_HIGH + 1, 10);
      low(LOWEND);
      rdc(4'h3, stv(0, 0, 1, 0, 0), "long_err");
      wr(4'h3, 32'h20);
      for (int i = 0; i < 24; i++) pulse(bw[i % 4], 8);
      low(LOWEND);
      rdc(4'h3, stv(1, 0, 0, 0, 1), "bound_st");
      rdc(4'h2, 32'h80333333, "bound_data");
      wr(4'h3, 32'hF0);

      for (int i = 0; i < 12; i++) rbit(1'($urandom));
      low(LOWEND);
      rdc(4'h3, stv(0, 0, 0, 1, 1), "partial_st");
      wr(4'h3, 32'hF0);
      rword(24'h5A5A0F);
      low(LOWEND);
      rdc(4'h2, 32'h805A5A0F, "after_partial");
      wr(4'h3, 32'hF0);

      rword(24'h0C0C0C);
      rword(24'hF00F00);
      low(LOWEND);
      rdc(4'h3, stv(2, 0, 0, 0, 1), "pre_flush");
      wr(4'h4, 32'h7);
      rdc(4'h3, stv(0, 0, 0, 0, 1), "flushed");
      rdc(4'h4, 32'h3, "ctrl_after_flush");
      rdc(4'h2, 32'h0, "flush_empty");
      wr(4'h3, 32'hF0);

      rword(24'hC0FFEE);
      for (int i = 0; i < 10; i++) rbit(1'($urandom));
      wr(4'h4, 32'h2);
      rdc(4'h3, stv(1, 0, 0, 0, 0), "en_off_keep");
      wr(4'h4, 32'h3);
      for (int i = 0; i < 14; i++) rbit(1'($urandom));
      low(LOWEND);
      rword(24'h00BEEF);
      low(LOWEND);
      rdc(4'h3, stv(2, 0, 0, 0, 1), "en_resume_st");
      rdc(4'h2, 32'h80C0FFEE, "en_d0");
      chk("irq_pre_rst", {31'b0, irq}, 32'h1);
      rdc(4'h3, stv(1, 0, 0, 0, 1), "pre_rst_st");

      rgb = 1'b1;
      step(10);
      resetn = 1'b0;
      #1;
      chk("mid_rst_ack", {31'b0, ack}, 32'h0);
      chk("mid_rst_rdata", rdata, 32'h0);
      chk("mid_rst_irq", {31'b0, irq}, 32'h0);
      step(3);
      resetn = 1'b1;
      step(1);
      rdc(4'h3, 32'h0, "post_rst_st");
      rdc(4'h4, 32'h0, "post_rst_ctrl");
      wr(4'h4, 32'h2);
      mon = 1'b1;
      low(LOWEND);
      rword(24'hABCDEF);
      low(LOWEND);
      mon = 1'b0;
      chk("dis_irq_never", {31'b0, irq_seen}, 32'h0);
      rdc(4'h3, 32'h0, "dis_st");

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
